// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter: FSM states, requester ids,
// access counter width and the protected-address compare helper.
package ram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } req_id_e;

    function automatic logic in_protected(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_select2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not
// served last.
module rr_select2
    import ram_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    ldr_req,
    input  req_id_e last_served,
    output req_id_e grant
);

    // Tie-break favours whichever requester did not get the previous access.
    always_comb begin
        grant = CPU;
        if (cpu_req && ldr_req) begin
            grant = (last_served == CPU) ? LDR : CPU;
        end else if (ldr_req) begin
            grant = LDR;
        end else begin
            grant = CPU;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// RAM arbiter: shares one single-ported RAM between a CPU and a loader.
// Optional CPU write protection at/above PROTECT_BASE via RAM_ARB_WRITE_PROTECT_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES  = 1,
    parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'hF0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpuReq,
    input  logic              i_cpuWrite,
    input  logic [ADDR_W-1:0] i_cpuAddr,
    input  logic [DATA_W-1:0] i_cpuData,
    output logic              o_cpuStall,
    output logic              o_cpuValid,
    output logic [DATA_W-1:0] o_cpuRdData,
    input  logic              i_ldrReq,
    input  logic              i_ldrWrite,
    input  logic [ADDR_W-1:0] i_ldrAddr,
    input  logic [DATA_W-1:0] i_ldrData,
    output logic              o_ldrValid,
    output logic [DATA_W-1:0] o_ldrRdData,
    output logic [ADDR_W-1:0] o_ramAddr,
    output logic [DATA_W-1:0] o_ramWrData,
    output logic              o_ramWe,
    output logic              o_ramOe,
    input  logic [DATA_W-1:0] i_ramRdData,
    output logic              o_cpuFault
);

    state_e            state;
    state_e            state_next;
    logic [CNT_W-1:0]  cnt;
    req_id_e           last_served;
    req_id_e           grant_pick;
    req_id_e           owner;
    logic              lat_write;
    logic              take_grant;
    logic              access_last;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              block_write;

    rr_select2 u_rr_select2 (
        .cpu_req     (i_cpuReq),
        .ldr_req     (i_ldrReq),
        .last_served (last_served),
        .grant       (grant_pick)
    );

    // Request fields of whichever requester the tie-break picked.
    always_comb begin
        sel_write = i_cpuWrite;
        sel_addr  = i_cpuAddr;
        sel_data  = i_cpuData;
        if (grant_pick == LDR) begin
            sel_write = i_ldrWrite;
            sel_addr  = i_ldrAddr;
            sel_data  = i_ldrData;
        end else begin
            sel_write = i_cpuWrite;
            sel_addr  = i_cpuAddr;
            sel_data  = i_cpuData;
        end
    end

    // Next-state logic; DONE never grants, so back-to-back accesses wait one IDLE cycle.
    always_comb begin
        state_next  = state;
        take_grant  = 1'b0;
        access_last = 1'b0;
        case (state)
            IDLE: begin
                if (i_cpuReq || i_ldrReq) begin
                    take_grant = 1'b1;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                if (cnt == CNT_ZERO) begin
                    access_last = 1'b1;
                    state_next  = DONE;
                end else begin
                    state_next = ACCESS;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the granted request, drive the RAM strobes, capture reads and pulse Valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt         <= CNT_ZERO;
            last_served <= CPU;
            owner       <= CPU;
            lat_write   <= 1'b0;
            o_ramAddr   <= {ADDR_W{1'b0}};
            o_ramWrData <= {DATA_W{1'b0}};
            o_ramWe     <= 1'b0;
            o_ramOe     <= 1'b0;
            o_cpuValid  <= 1'b0;
            o_ldrValid  <= 1'b0;
            o_cpuRdData <= {DATA_W{1'b0}};
            o_ldrRdData <= {DATA_W{1'b0}};
        end else begin
            o_cpuValid <= 1'b0;
            o_ldrValid <= 1'b0;
            if (take_grant) begin
                owner       <= grant_pick;
                last_served <= grant_pick;
                lat_write   <= sel_write;
                o_ramAddr   <= sel_addr;
                o_ramWrData <= sel_data;
                o_ramWe     <= sel_write & ~block_write;
                o_ramOe     <= ~sel_write;
                cnt         <= CNT_W'(WAIT_CYCLES);
            end else if (access_last) begin
                o_ramWe <= 1'b0;
                o_ramOe <= 1'b0;
                if (owner == CPU) begin
                    o_cpuValid <= 1'b1;
                    if (!lat_write) begin
                        o_cpuRdData <= i_ramRdData;
                    end
                end else begin
                    o_ldrValid <= 1'b1;
                    if (!lat_write) begin
                        o_ldrRdData <= i_ramRdData;
                    end
                end
            end else if (state == ACCESS) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign o_cpuStall = i_cpuReq & ~o_cpuValid;

`ifdef RAM_ARB_WRITE_PROTECT_EN
    logic cpu_fault;

    assign block_write = (grant_pick == CPU) && sel_write && in_protected(sel_addr, PROTECT_BASE);

    // Sticky fault: set by any blocked CPU write, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cpu_fault <= 1'b0;
        end else if (take_grant && block_write) begin
            cpu_fault <= 1'b1;
        end else begin
            cpu_fault <= cpu_fault;
        end
    end

    assign o_cpuFault = cpu_fault;
`else
    logic [ADDR_W-1:0] unused_protect_base;

    assign unused_protect_base = PROTECT_BASE;
    assign block_write         = 1'b0;
    assign o_cpuFault          = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed corner cases and a
// random run against a transaction-level model (grant time, fixed latency, memory array).
module tb_ram_arbiter;

    localparam int W = 1;
`ifdef RAM_ARB_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_write, ldr_req, ldr_write;
    logic [7:0] cpu_addr, cpu_data, ldr_addr, ldr_data;
    logic       cpu_stall, cpu_valid, ldr_valid, ram_we, ram_oe, cpu_fault;
    logic [7:0] cpu_rd, ldr_rd, ram_addr, ram_wdata, ram_rd;
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem [256];
    logic [7:0] model_mem [256];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    typedef struct {
        bit         cr;
        bit         cw;
        logic [7:0] ca;
        logic [7:0] cd;
        bit         lr;
        bit         lw;
        logic [7:0] la;
        logic [7:0] ld;
        bit         exp_ldr_first;
        logic [7:0] exp_crd;
        logic [7:0] exp_lrd;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    ram_arbiter #(.WAIT_CYCLES(W), .PROTECT_BASE(8'hF0)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpuReq(cpu_req), .i_cpuWrite(cpu_write), .i_cpuAddr(cpu_addr), .i_cpuData(cpu_data),
        .o_cpuStall(cpu_stall), .o_cpuValid(cpu_valid), .o_cpuRdData(cpu_rd),
        .i_ldrReq(ldr_req), .i_ldrWrite(ldr_write), .i_ldrAddr(ldr_addr), .i_ldrData(ldr_data),
        .o_ldrValid(ldr_valid), .o_ldrRdData(ldr_rd),
        .o_ramAddr(ram_addr), .o_ramWrData(ram_wdata), .o_ramWe(ram_we), .o_ramOe(ram_oe),
        .i_ramRdData(ram_rd), .o_cpuFault(cpu_fault)
    );

    // Simple asynchronous-read RAM; the bench can preload it through pre_we.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rd = mem[ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input int id, input bit rq, input bit wr,
                           input logic [7:0] a, input logic [7:0] d);
        if (id == 0) begin
            cpu_req = rq; cpu_write = wr; cpu_addr = a; cpu_data = d;
        end else begin
            ldr_req = rq; ldr_write = wr; ldr_addr = a; ldr_data = d;
        end
    endtask

    // Reset the DUT while filling the RAM (and the model copy) with addr ^ 8'h5A.
    task automatic fill();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        pre_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_addr = 8'(i);
            pre_data = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
            step();
        end
        pre_we = 1'b0;
        check("rst_ram_addr", ram_addr, 8'h00);
        check("rst_ram_wdata", ram_wdata, 8'h00);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_oe", ram_oe, 1'b0);
        check("rst_cpu_valid", cpu_valid, 1'b0);
        check("rst_ldr_valid", ldr_valid, 1'b0);
        check("rst_cpu_rd", cpu_rd, 8'h00);
        check("rst_ldr_rd", ldr_rd, 8'h00);
        check("rst_fault", cpu_fault, 1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        rst = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
        model_mem[a] = d;
    endtask

    // One access by one requester; fields switch to a2/~d right after the grant edge.
    task automatic run_op(input bit ldr, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] a2, output int lat, output int we_n, output int oe_n,
                          output int bad, output bit got, output logic [7:0] rd, output bit stall_v);
        lat = 0; we_n = 0; oe_n = 0; bad = 0; got = 1'b0; rd = 8'h00; stall_v = 1'b1;
        set_req(ldr ? 1 : 0, 1'b1, wr, a, d);
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            lat++;
            if (k == 0) set_req(ldr ? 1 : 0, 1'b1, wr, a2, ~d);
            if (ram_we) we_n++;
            if (ram_oe) oe_n++;
            if ((ram_we || ram_oe) && ram_addr !== a) bad++;
            if (ldr ? ldr_valid : cpu_valid) begin
                got = 1'b1;
                rd = ldr ? ldr_rd : cpu_rd;
                stall_v = cpu_stall;
            end
        end
        set_req(ldr ? 1 : 0, 1'b0, wr, a2, d);
        step();
        check("valid_single_cycle", ldr ? ldr_valid : cpu_valid, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit seen_c, seen_l, first_l, first_set;
        seen_c = 1'b0; seen_l = 1'b0; first_l = 1'b0; first_set = 1'b0;
        set_req(0, v.cr, v.cw, v.ca, v.cd);
        set_req(1, v.lr, v.lw, v.la, v.ld);
        for (int k = 0; k < 40 && !((seen_c || !v.cr) && (seen_l || !v.lr)); k++) begin
            step();
            if (cpu_valid) begin
                if (!first_set) begin first_set = 1'b1; first_l = 1'b0; end
                seen_c = 1'b1;
                cpu_req = 1'b0;
            end
            if (ldr_valid) begin
                if (!first_set) begin first_set = 1'b1; first_l = 1'b1; end
                seen_l = 1'b1;
                ldr_req = 1'b0;
            end
        end
        check($sformatf("vec%0d_done", idx), (seen_c == v.cr) && (seen_l == v.lr), 1'b1);
        check($sformatf("vec%0d_first_ldr", idx), first_l, v.exp_ldr_first);
        check($sformatf("vec%0d_cpu_rd", idx), cpu_rd, v.exp_crd);
        check($sformatf("vec%0d_ldr_rd", idx), ldr_rd, v.exp_lrd);
        step();
    endtask

    function automatic logic [7:0] rnd_addr();
        logic [3:0] lo;
        lo = 4'($urandom_range(0, 3));
        return {($urandom_range(0, 1) == 1) ? 4'hF : 4'h4, lo};
    endfunction

    initial begin
        int         lat, we_n, oe_n, bad;
        bit         got, stall_v;
        logic [7:0] rd;
        bit         m_last_ldr, p_act, p_ldr, p_rd, m_fault, w;
        bit         r_act [2];
        bit         r_granted [2];
        bit         ev [2];
        logic [7:0] m_rd [2];
        logic [7:0] p_val, ga, gd;
        bit         gw;
        int         p_done, free_at;

        // mem[a] = a ^ 5A after fill; reads return that unless written earlier in the table.
        vt[0] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 8'h48, 8'h6E};
        vt[1] = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h5B, 8'h58};
        vt[2] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b1, 8'h12, 8'h77, 1'b1, 8'h77, 8'h58};
        vt[3] = '{1'b1, 1'b1, 8'h34, 8'h11, 1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 8'h77, 8'h6E};
        vt[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 8'h77, 8'h11};
        vt[5] = '{1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 1'b1, 8'h34, 8'h22, 1'b0, 8'h11, 8'h11};
        vt[6] = '{1'b1, 1'b0, 8'h34, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h22, 8'h11};
        vt[7] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 8'h1A, 8'h1B};

        pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        fill();
        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // CPU read of 8'h12 returning 8'hA5; Valid is the (W+3)th cycle counting the request cycle.
        poke(8'h12, 8'hA5);
        run_op(1'b0, 1'b0, 8'h12, 8'h00, 8'h12, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("cpu_rd_got", got, 1'b1);
        check("cpu_rd_latency_edges", lat, W + 2);
        check("cpu_rd_oe_cycles", oe_n, W + 1);
        check("cpu_rd_data", rd, 8'hA5);
        check("cpu_rd_stall_in_valid", stall_v, 1'b0);

        // Loader write then read back through the RAM.
        run_op(1'b1, 1'b1, 8'h40, 8'h3C, 8'h40, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("ldr_wr_we_cycles", we_n, W + 1);
        check("ldr_wr_got", got, 1'b1);
        run_op(1'b1, 1'b0, 8'h40, 8'h00, 8'h40, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("ldr_readback", rd, 8'h3C);

        // Fields change after grant: the latched address must stay on the RAM.
        run_op(1'b0, 1'b0, 8'h01, 8'h00, 8'h02, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("field_change_addr_held", bad, 0);
        check("field_change_oe_cycles", oe_n, W + 1);
        check("field_change_rd", rd, 8'h5B);

        // Reset in the second ACCESS cycle of a CPU read.
        set_req(0, 1'b1, 1'b0, 8'h12, 8'h00);
        step();
        check("abort_oe_access1", ram_oe, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_no_valid", cpu_valid, 1'b0);
        check("abort_oe_low", ram_oe, 1'b0);
        check("abort_cpu_rd_zero", cpu_rd, 8'h00);
        lat = 0; got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            lat++;
            if (cpu_valid) got = 1'b1;
        end
        check("abort_regrant_latency", lat, W + 2);
        check("abort_regrant_rd", cpu_rd, 8'hA5);
        cpu_req = 1'b0;
        step();

        // CPU/loader writes into the protectable region.
        run_op(1'b0, 1'b1, 8'hF5, 8'h66, 8'hF5, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("prot_cpu_valid", got, 1'b1);
`ifdef RAM_ARB_WRITE_PROTECT_EN
        check("prot_cpu_we_blocked", we_n, 0);
        check("prot_fault_set", cpu_fault, 1'b1);
        step(); step(); step();
        check("prot_fault_held", cpu_fault, 1'b1);
        run_op(1'b1, 1'b1, 8'hF5, 8'h77, 8'hF5, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("prot_ldr_we", we_n, W + 1);
        check("prot_fault_still", cpu_fault, 1'b1);
        run_op(1'b1, 1'b0, 8'hF5, 8'h00, 8'hF5, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("prot_ldr_readback", rd, 8'h77);
`else
        check("noprot_cpu_we", we_n, W + 1);
        check("noprot_fault_zero", cpu_fault, 1'b0);
        run_op(1'b1, 1'b0, 8'hF5, 8'h00, 8'hF5, lat, we_n, oe_n, bad, got, rd, stall_v);
        check("noprot_readback", rd, 8'h66);
`endif

        // Random traffic against a transaction-level model.
        fill();
        m_last_ldr = 1'b0; p_act = 1'b0; p_ldr = 1'b0; p_rd = 1'b0; p_val = 8'h00;
        m_fault = 1'b0; p_done = 0; free_at = cyc + 1;
        for (int id = 0; id < 2; id++) begin
            r_act[id] = 1'b0; r_granted[id] = 1'b0; m_rd[id] = 8'h00;
        end
        for (int n = 0; n < 800; n++) begin
            step();
            if (!p_act && cyc >= free_at && (cpu_req || ldr_req)) begin
                w  = (cpu_req && ldr_req) ? !m_last_ldr : ldr_req;
                gw = w ? ldr_write : cpu_write;
                ga = w ? ldr_addr : cpu_addr;
                gd = w ? ldr_data : cpu_data;
                p_act = 1'b1; p_ldr = w; p_rd = !gw;
                p_done = cyc + W + 1;
                free_at = cyc + W + 3;
                m_last_ldr = w;
                r_granted[w ? 1 : 0] = 1'b1;
                if (gw) begin
                    if (PROT && !w && ga >= 8'hF0) m_fault = 1'b1;
                    else model_mem[ga] = gd;
                end else begin
                    p_val = model_mem[ga];
                end
            end
            ev[0] = p_act && (p_done == cyc) && !p_ldr;
            ev[1] = p_act && (p_done == cyc) && p_ldr;
            if (ev[0] || ev[1]) begin
                if (p_rd) m_rd[p_ldr ? 1 : 0] = p_val;
                p_act = 1'b0;
            end
            check("rnd_cpu_valid", cpu_valid, ev[0]);
            check("rnd_ldr_valid", ldr_valid, ev[1]);
            check("rnd_cpu_rd", cpu_rd, m_rd[0]);
            check("rnd_ldr_rd", ldr_rd, m_rd[1]);
            check("rnd_cpu_stall", cpu_stall, cpu_req && !ev[0]);
            if (ev[0]) check("rnd_fault", cpu_fault, m_fault);
            for (int id = 0; id < 2; id++) begin
                if (ev[id]) begin
                    r_act[id] = 1'b0;
                    r_granted[id] = 1'b0;
                    set_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
                end else if (r_granted[id]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(id, (id == 0) ? cpu_req : ldr_req, 1'($urandom_range(0, 1)),
                                rnd_addr(), 8'($urandom));
                    if ($urandom_range(0, 9) == 0) begin
                        if (id == 0) cpu_req = 1'b0;
                        else ldr_req = 1'b0;
                    end
                end
                if (!r_act[id] && n < 760 && $urandom_range(0, 2) == 0) begin
                    set_req(id, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom));
                    r_act[id] = 1'b1;
                end
            end
        end
        check("rnd_drained", r_act[0] || r_act[1], 1'b0);
        check("rnd_fault_end", cpu_fault, m_fault);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
